// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Imported by the channel and the top level.
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // High-phase length ceil(d/2); evaluated at 32 bits so d+1 cannot wrap.
    function automatic int unsigned hi_len(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: phase counter, active/pending divisor and
// registered divided-output and period-start tick.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             ready_o,
    output logic             div_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dcur_q, dcur_d;
    logic [DIV_W-1:0] dpend_q, dpend_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   hi;
    logic             last;

    assign hi      = (DIV_W+1)'(hi_len(32'(dcur_q)));
    assign last    = (cnt_q == dcur_q - DIV_W'(1));
    assign ready_o = !pend_q;
    assign div_o   = div_q;
    assign tick_o  = tick_q;

    always_comb begin
        cnt_d   = cnt_q;
        dcur_d  = dcur_q;
        dpend_d = dpend_q;
        pend_d  = pend_q;
        div_d   = div_q;
        tick_d  = tick_q;
        if (!en_i || restart_i) begin
            // Idle/re-phase: flush any divisor straight into use.
            cnt_d  = '0;
            div_d  = 1'b0;
            tick_d = 1'b0;
            pend_d = 1'b0;
            if (wr_en_i) begin
                dcur_d = wr_div_i;
            end else if (pend_q) begin
                dcur_d = dpend_q;
            end
        end else begin
            tick_d = (cnt_q == '0);
            div_d  = ({1'b0, cnt_q} < hi);
            if (last) begin
                cnt_d = '0;
                if (pend_q) begin
                    dcur_d = dpend_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (wr_en_i) begin
                dpend_d = wr_div_i;
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            dcur_q  <= DIV_W'(DEFAULT_DIV);
            dpend_q <= '0;
            pend_q  <= 1'b0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dcur_q  <= dcur_d;
            dpend_q <= dpend_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator: config decode,
// write rejection and one divider channel per output bit.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] wr_en;
    logic              in_range;
    logic              ready_sel;
    logic              accept;
    logic              bad;
    logic              err_q, err_d;

    // Out-of-range channels report ready so the bad write completes.
    always_comb begin
        in_range  = 1'b0;
        ready_sel = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                in_range  = 1'b1;
                ready_sel = ch_ready[i];
            end
        end
    end

    assign cfg_ready = ready_sel;
    assign accept    = cfg_valid && ready_sel;
    assign bad       = (cfg_div == '0) || !in_range;
    assign err_d     = accept && bad;
    assign cfg_err   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en[g] = accept && !bad && (cfg_ch == CH_W'(g));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en),
            .restart_i (sync_restart),
            .wr_en_i   (wr_en[g]),
            .wr_div_i  (cfg_div),
            .ready_o   (ch_ready[g]),
            .div_o     (div_out[g]),
            .tick_o    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi against a
// phase-based reference model of each channel's waveform.
module tb_clk_div_multi;

    localparam int NUM_CH      = 5;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int CH_W        = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en = 1'b0;
    logic              sync_restart = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase within period, active and queued divisor per channel.
    int                ph[NUM_CH];
    int                dcur[NUM_CH];
    int                dpend[NUM_CH];
    bit                pend[NUM_CH];
    logic [NUM_CH-1:0] e_div;
    logic [NUM_CH-1:0] e_tick;
    logic              e_err;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_err      (cfg_err),
        .div_out      (div_out),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            ph[c]    = 0;
            dcur[c]  = DEFAULT_DIV;
            dpend[c] = 0;
            pend[c]  = 0;
        end
        e_div  = '0;
        e_tick = '0;
        e_err  = 1'b0;
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !pend[cfg_ch];
    endfunction

    task automatic model_edge();
        bit acc, bad, wr, w;
        acc   = cfg_valid && model_ready();
        bad   = (cfg_div == 0) || (int'(cfg_ch) >= NUM_CH);
        e_err = acc && bad;
        wr    = acc && !bad;
        for (int c = 0; c < NUM_CH; c++) begin
            w = wr && (int'(cfg_ch) == c);
            if (!en || sync_restart) begin
                ph[c]     = 0;
                e_div[c]  = 1'b0;
                e_tick[c] = 1'b0;
                if (pend[c]) dcur[c] = dpend[c];
                pend[c] = 0;
                if (w) dcur[c] = int'(cfg_div);
            end else begin
                e_tick[c] = (ph[c] == 0);
                e_div[c]  = (ph[c] < (dcur[c] + 1) / 2);
                ph[c]     = ph[c] + 1;
                if (ph[c] == dcur[c]) begin
                    ph[c] = 0;
                    if (pend[c]) begin
                        dcur[c] = dpend[c];
                        pend[c] = 0;
                    end
                end
                if (w) begin
                    dpend[c] = int'(cfg_div);
                    pend[c]  = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        #2;
        chk("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("div_out", 32'(div_out), 32'(e_div));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int ch, input int dv);
        int k;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        k = 0;
        while (!model_ready() && k < 600) begin
            cycle();
            k++;
        end
        chk("wr_wait", 32'(k < 600), 32'd1);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_div", 32'(div_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        #10;
        rst = 1'b1;
        en  = 1'b1;
        run(8);

        run(1);
        wr(1, 5);
        cfg_ch = CH_W'(1);
        run(14);

        wr(2, 1);
        run(6);
        wr(2, 255);
        run(520);

        wr(0, 0);
        run(2);
        wr(5, 9);
        run(2);
        wr(7, 3);
        run(2);

        wr(0, 3);
        wr(1, 4);
        wr(2, 6);
        wr(3, 7);
        run(10);
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        run(30);

        wr(0, 6);
        en = 1'b0;
        run(4);
        en = 1'b1;
        run(20);

        en = 1'b0;
        wr(4, 5);
        run(2);
        en = 1'b1;
        run(12);

        for (int i = 0; i < 400; i++) begin
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = CH_W'($urandom_range(0, 7));
            cfg_div      = ($urandom_range(0, 9) == 0) ? '0
                           : DIV_W'($urandom_range(1, 12));
            en           = ($urandom_range(0, 19) != 0);
            sync_restart = ($urandom_range(0, 29) == 0);
            cycle();
        end
        cfg_valid    = 1'b0;
        en           = 1'b1;
        sync_restart = 1'b0;
        run(10);

        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_div", 32'(div_out), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_err", 32'(cfg_err), 32'd0);
        #2;
        rst = 1'b1;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed power-of-two clock divider.
- Each channel divides clk by a runtime-programmable integer D (1..2^DIV_W-1).
- Each channel produces a near-50% duty divided output plus a one-cycle period-start tick.
- Used as the common clock-enable/strobe generator for downstream peripherals; all logic is on clk, and no divided signal is used as a clock.

Parameters:
- NUM_CH, 4: number of independent divider channels (>=1).
- DIV_W, 8: divisor and counter width.
- DEFAULT_DIV, 2: divisor loaded into every channel at reset (1..2^DIV_W-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 holds all channels idle
- sync_restart  in  1  single-cycle pulse; re-phases all channels to count 0
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  combinational; 1 when the addressed channel can accept a divisor
- cfg_ch  in  CH_W=max(1,clog2(NUM_CH))  target channel
- cfg_div  in  DIV_W  new divisor D
- cfg_err  out  1  registered one-cycle pulse on a rejected write
- div_out  out  NUM_CH  divided outputs, bit i = channel i
- tick  out  NUM_CH  one-cycle pulse at the start of each channel period

Behaviour:
- Reset (rst=0, async): all cnt=0, all D_cur=DEFAULT_DIV, all pending=0, div_out=0, tick=0, cfg_err=0.
- Per-channel state: cnt[DIV_W], D_cur[DIV_W], D_pend[DIV_W], pending flag.
- hi = ceil(D_cur/2), computed as (D_cur+1)>>1 at DIV_W+1 bits with no overflow.
- Normal edge (en=1, sync_restart=0):
  - tick <= (cnt==0).
  - div_out <= (cnt < hi).
  - cnt <= (cnt==D_cur-1) ? 0 : cnt+1.
- Outputs are registered and lag cnt by one cycle.
- Resulting waveform:
  - Period is D_cur cycles.
  - div_out is high for ceil(D/2) cycles and low for floor(D/2) cycles.
  - tick coincides with the first high cycle.
- D=1: div_out is constantly 1 and tick is 1 every cycle.
- Config handshake: a write is accepted when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch] when cfg_ch < NUM_CH; cfg_ready = 1 when cfg_ch is out of range.
  - Rejected writes (cfg_div==0 or cfg_ch>=NUM_CH): cfg_err pulses 1 on the next cycle and no state changes.
  - An accepted write stores D_pend and sets pending.
  - The pending value is applied at the period boundary: on the edge where cnt==D_cur-1, D_cur<=D_pend, pending<=0, and cnt<=0.
  - No truncated or stretched period is ever produced.
- en=0 has highest priority:
  - cnt<=0, div_out<=0, tick<=0.
  - Any pending divisor is applied immediately.
  - A write accepted in the same cycle goes straight into D_cur, with no pending.
- First enabled edge after en rises: tick=1 and div_out=1 on the following cycle.
- sync_restart=1 with en=1:
  - All channels: cnt<=0, div_out<=0, tick<=0.
  - Pending divisors are applied; a write accepted in the same cycle is applied directly.
  - The next edge starts phase 0, so all channels are phase-aligned.
- Priority order: rst > en=0 > sync_restart > boundary update > normal count.
- Reset assertion mid-period aborts immediately; no partial state is retained.

Decomposition:
- Package clk_div_pkg holds:
  - the DIV_W default;
  - the CH_W function (max(1,clog2));
  - the hi-length function ceil(D/2).
- Sub-module clk_div_channel holds one channel's cnt, D_cur, D_pend, pending and output flops.
  - Its inputs: en, restart, wr_en, wr_div.
  - Its output: ready.
- Top level:
  - decodes cfg_ch and rejects bad writes;
  - generates cfg_err;
  - instantiates NUM_CH channels with a generate loop.

Test Plan:
- Reset, en=1, defaults (D=2): every div_out toggles 1,0,1,0; tick = 1,0,1,0 aligned with the highs; cfg_ready=1.
- Write ch1 D=5 mid-period: ch1 finishes its current 2-cycle period, then repeats high 3 / low 2 with tick every 5 cycles; cfg_ready for ch1 is 0 until the boundary; other channels are unaffected.
- Write ch2 D=1, then D=255: D=1 gives div_out=1 and tick=1 every cycle; D=255 gives 128 high / 127 low with no overflow in the hi computation.
- Write cfg_div=0 and cfg_ch=NUM_CH: cfg_err is a one-cycle pulse each time, and no divisor changes.
- Channels set to D=3,4,6,7, then a sync_restart pulse: one cycle of all outputs=0, then all ticks=1 on the same cycle and the periods restart aligned.
- Drop en mid-period with ch0 pending D=6, then raise en: outputs=0 while disabled; ch0 resumes with a D=6 period starting tick=1. Also assert rst mid-period and check every output goes 0 asynchronously.
